// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    MST_IFU = 1'b0,
    MST_LSU = 1'b1
  } mst_e;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of the IFU/LSU request-response ports and the downstream memory port.
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic                ifu_req_valid;
  logic                ifu_req_ready;
  logic [ADDR_W-1:0]   ifu_req_addr;
  logic                ifu_req_wen;
  logic [DATA_W-1:0]   ifu_req_wdata;
  logic [DATA_W/8-1:0] ifu_req_wmask;
  logic                ifu_rsp_valid;
  logic [DATA_W-1:0]   ifu_rsp_rdata;
  logic                ifu_rsp_err;

  logic                lsu_req_valid;
  logic                lsu_req_ready;
  logic [ADDR_W-1:0]   lsu_req_addr;
  logic                lsu_req_wen;
  logic [DATA_W-1:0]   lsu_req_wdata;
  logic [DATA_W/8-1:0] lsu_req_wmask;
  logic                lsu_rsp_valid;
  logic [DATA_W-1:0]   lsu_rsp_rdata;
  logic                lsu_rsp_err;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic                mem_req_wen;
  logic [DATA_W-1:0]   mem_req_wdata;
  logic [DATA_W/8-1:0] mem_req_wmask;
  logic                mem_rsp_valid;
  logic [DATA_W-1:0]   mem_rsp_rdata;
  logic                mem_rsp_err;

  logic                busy;

  // Arbiter side.
  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_req_wen, ifu_req_wdata, ifu_req_wmask,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    output busy
  );

  // Environment side (requesters and memory).
  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_req_wen, ifu_req_wdata, ifu_req_wmask,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    input  busy
  );

endinterface

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker: a tie goes to whichever master was not granted last.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic i_ifu_valid,
  input  logic i_lsu_valid,
  input  mst_e i_last_grant,
  output mst_e o_grant
);

  always_comb begin
    o_grant = MST_IFU;
    if (i_ifu_valid && i_lsu_valid) begin
      o_grant = (i_last_grant == MST_IFU) ? MST_LSU : MST_IFU;
    end else if (i_lsu_valid) begin
      o_grant = MST_LSU;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// IFU/LSU memory arbiter: one outstanding transaction, round-robin grant,
// registered downstream request and a response-wait timeout.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 255
)(
  input  logic      clk,
  input  logic      rst_n,
  mem_arb_if.slave  bus
);

  localparam int unsigned        MASK_W      = DATA_W / 8;
  localparam logic [CNT_W-1:0]   LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  mst_e                r_last_grant;
  mst_e                r_owner;
  mst_e                w_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;
  logic [CNT_W-1:0]    r_wait_cnt;

  logic                w_accept;
  logic                w_issue_done;
  logic                w_rsp_fire;
  logic                w_rsp_err;
  logic [DATA_W-1:0]   w_rsp_rdata;

  mem_arb_rr2 u_rr2 (
    .i_ifu_valid  (bus.ifu_req_valid),
    .i_lsu_valid  (bus.lsu_req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= MST_LSU;
      r_owner      <= MST_IFU;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_grant;
      r_owner      <= w_grant;
      if (w_grant == MST_IFU) begin
        r_addr  <= bus.ifu_req_addr;
        r_wen   <= bus.ifu_req_wen;
        r_wdata <= bus.ifu_req_wdata;
        r_wmask <= bus.ifu_req_wmask;
      end else begin
        r_addr  <= bus.lsu_req_addr;
        r_wen   <= bus.lsu_req_wen;
        r_wdata <= bus.lsu_req_wdata;
        r_wmask <= bus.lsu_req_wmask;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_issue_done) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ST_WAIT) && !bus.mem_rsp_valid) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  // Everything is gated by rst_n so the outputs fall the instant reset asserts.
  always_comb begin
    w_state_nxt       = r_state;
    w_accept          = 1'b0;
    w_issue_done      = 1'b0;
    w_rsp_fire        = 1'b0;
    w_rsp_err         = 1'b0;
    w_rsp_rdata       = '0;
    bus.ifu_req_ready = 1'b0;
    bus.lsu_req_ready = 1'b0;
    bus.mem_req_valid = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        ST_IDLE: begin
          bus.ifu_req_ready = bus.ifu_req_valid && (w_grant == MST_IFU);
          bus.lsu_req_ready = bus.lsu_req_valid && (w_grant == MST_LSU);
          if (bus.ifu_req_valid || bus.lsu_req_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          bus.mem_req_valid = 1'b1;
          if (bus.mem_req_ready) begin
            w_issue_done = 1'b1;
            w_state_nxt  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A real response beats a timeout expiring in the same cycle.
          if (bus.mem_rsp_valid) begin
            w_rsp_fire  = 1'b1;
            w_rsp_rdata = bus.mem_rsp_rdata;
            w_rsp_err   = bus.mem_rsp_err;
            w_state_nxt = ST_IDLE;
          end else if (r_wait_cnt == LP_CNT_LAST) begin
            w_rsp_fire  = 1'b1;
            w_rsp_err   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ifu_rsp_valid = w_rsp_fire && (r_owner == MST_IFU);
    bus.lsu_rsp_valid = w_rsp_fire && (r_owner == MST_LSU);
    bus.ifu_rsp_rdata = bus.ifu_rsp_valid ? w_rsp_rdata : '0;
    bus.lsu_rsp_rdata = bus.lsu_rsp_valid ? w_rsp_rdata : '0;
    bus.ifu_rsp_err   = bus.ifu_rsp_valid && w_rsp_err;
    bus.lsu_rsp_err   = bus.lsu_rsp_valid && w_rsp_err;
    bus.busy          = rst_n && (r_state != ST_IDLE);
  end

  assign bus.mem_req_addr  = r_addr;
  assign bus.mem_req_wen   = r_wen;
  assign bus.mem_req_wdata = r_wdata;
  assign bus.mem_req_wmask = r_wmask;

endmodule
